// File: rtl/uart_matrix_loader.sv
// uart_matrix_loader: parses UART command/payload frames into operand RAM writes and launches the multiply.
// Latency: RAM write strobes and mm_start appear one cycle after the rx_valid byte that causes them.
// Backpressure: none; every rx_valid byte is consumed or dropped. Optional LOADER_CHECKSUM_EN adds a trailing XOR check byte.
module uart_matrix_loader #(
  parameter int N       = 4,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mm_start,
  input  logic              mm_done,
  output logic              busy,
  output logic              err,
  output logic              a_loaded,
  output logic              b_loaded
);

  localparam logic [7:0] CMD_A  = 8'hA1;
  localparam logic [7:0] CMD_B  = 8'hB2;
  localparam logic [7:0] CMD_GO = 8'h5A;
  localparam int         TW     = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N * N - 1);
  localparam logic [TW-1:0]     TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_START,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              a_ld_q, a_ld_d;
  logic              b_ld_q, b_ld_d;
  logic              tmo_fire;
  logic [TW-1:0]     tmo_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  // Idle-gap counter: the TIMEOUT-th quiet cycle aborts, a byte in that cycle wins.
  always_comb begin
    tmo_fire = !rx_valid && (tmo_q == TMO_LAST);
    tmo_next = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
  end

  // Next-state and registered-output decode for the frame parser.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    sel_d   = sel_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    a_ld_d  = a_ld_q;
    b_ld_d  = b_ld_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_A || rx_data == CMD_B) begin
            err_d   = 1'b0;
            cnt_d   = '0;
            tmo_d   = '0;
            sel_d   = (rx_data == CMD_B);
            if (rx_data == CMD_B) b_ld_d = 1'b0;
            else                  a_ld_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_d  = rx_data;
`endif
            state_d = S_LOAD;
          end else if (rx_data == CMD_GO) begin
            if (a_ld_q && b_ld_q) state_d = S_START;
            else                  err_d   = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (rx_valid) begin
          tmo_d   = '0;
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = rx_data;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
          if (cnt_q == LAST_IDX) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            if (sel_q) b_ld_d = 1'b1;
            else       a_ld_d = 1'b1;
            state_d = S_IDLE;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_fire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_next;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          tmo_d = '0;
          if (rx_data == csum_q) begin
            if (sel_q) b_ld_d = 1'b1;
            else       a_ld_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end else if (tmo_fire) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_next;
        end
      end
`endif
      S_START: state_d = S_WAIT;
      S_WAIT:  if (mm_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset returns everything to an empty, idle loader.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      a_ld_q  <= 1'b0;
      b_ld_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      a_ld_q  <= a_ld_d;
      b_ld_q  <= b_ld_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Output map: start pulse and busy fall straight out of the state register.
  always_comb begin
    mem_we    = we_q;
    mem_sel   = sel_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mm_start  = (state_q == S_START);
    busy      = (state_q != S_IDLE);
    err       = err_q;
    a_loaded  = a_ld_q;
    b_loaded  = b_ld_q;
  end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Testbench for uart_matrix_loader: directed frames plus random byte traffic against a frame-level model.
// Outputs are compared every cycle, 1 time unit after the rising edge.
// Optional LOADER_CHECKSUM_EN build is followed by the model and the checksum directed case.
module tb_uart_matrix_loader;

  localparam int N       = 4;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 1023;
  localparam int NN      = N * N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              mem_we, mem_sel, mm_start, busy, err, a_loaded, b_loaded;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mm_done = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame-level view of the loader.
  // mode: 0 idle, 1 receiving payload, 2 awaiting checksum, 3 start pulse, 4 waiting for done
  int m_mode, m_sel, m_cnt, m_idle, m_csum, m_a, m_b, m_err;
  int e_we, e_addr, e_wdata;

  uart_matrix_loader #(.N(N), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mm_start(mm_start), .mm_done(mm_done), .busy(busy), .err(err),
    .a_loaded(a_loaded), .b_loaded(b_loaded)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit chk_en();
`ifdef LOADER_CHECKSUM_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sel = 0; m_cnt = 0; m_idle = 0; m_csum = 0;
    m_a = 0; m_b = 0; m_err = 0; e_we = 0; e_addr = 0; e_wdata = 0;
  endtask

  task automatic model_flag();
    if (m_sel == 1) m_b = 1; else m_a = 1;
  endtask

  task automatic model_quiet();
    m_idle++;
    if (m_idle >= TIMEOUT) begin
      m_err  = 1;
      m_mode = 0;
    end
  endtask

  task automatic model_step(input bit v, input int d, input bit done);
    e_we = 0;
    case (m_mode)
      0: if (v) begin
           if (d == 'hA1 || d == 'hB2) begin
             m_err = 0;
             m_sel = (d == 'hB2) ? 1 : 0;
             if (m_sel == 1) m_b = 0; else m_a = 0;
             m_cnt = 0; m_idle = 0; m_csum = d; m_mode = 1;
           end else if (d == 'h5A) begin
             if (m_a == 1 && m_b == 1) m_mode = 3; else m_err = 1;
           end
         end
      1: if (v) begin
           e_we = 1; e_addr = m_cnt; e_wdata = d;
           m_csum = m_csum ^ d; m_idle = 0; m_cnt++;
           if (m_cnt == NN) begin
             if (chk_en()) m_mode = 2;
             else begin model_flag(); m_mode = 0; end
           end
         end else model_quiet();
      2: if (v) begin
           if (d == m_csum) model_flag(); else m_err = 1;
           m_mode = 0;
         end else model_quiet();
      3: m_mode = 4;
      4: if (done) m_mode = 0;
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_all(input string ph);
    check_eq({ph, ".mem_we"},   mem_we,   e_we);
    check_eq({ph, ".mem_sel"},  mem_sel,  m_sel);
    if (e_we == 1) begin
      check_eq({ph, ".mem_addr"},  mem_addr,  e_addr);
      check_eq({ph, ".mem_wdata"}, mem_wdata, e_wdata);
    end
    check_eq({ph, ".mm_start"}, mm_start, (m_mode == 3));
    check_eq({ph, ".busy"},     busy,     (m_mode != 0));
    check_eq({ph, ".err"},      err,      m_err);
    check_eq({ph, ".a_loaded"}, a_loaded, m_a);
    check_eq({ph, ".b_loaded"}, b_loaded, m_b);
  endtask

  // One clock cycle: inputs applied now (just after an edge), compared just after the next edge.
  task automatic step(input string ph, input bit v, input int d, input bit done);
    rx_valid = v;
    rx_data  = 8'(d);
    mm_done  = done;
    model_step(v, d, done);
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  task automatic send(input string ph, input int d);
    step(ph, 1'b1, d, 1'b0);
  endtask

  task automatic quiet(input string ph, input int n);
    for (int i = 0; i < n; i++) step(ph, 1'b0, 0, 1'b0);
  endtask

  task automatic apply_reset(input string ph);
    rx_valid = 1'b0; mm_done = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_eq({ph, ".rst_mem_we"}, mem_we, 0);
    check_eq({ph, ".rst_busy"},   busy,   0);
    check_eq({ph, ".rst_err"},    err,    0);
    check_eq({ph, ".rst_a"},      a_loaded, 0);
    check_eq({ph, ".rst_b"},      b_loaded, 0);
    check_eq({ph, ".rst_start"},  mm_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_all(ph);
  endtask

  // Header, payload base+i*inc, and a correct checksum byte when that build option is on.
  task automatic load_matrix(input string ph, input int hdr, input int base, input int inc);
    int cs;
    cs = hdr;
    send(ph, hdr);
    for (int i = 0; i < NN; i++) begin
      send(ph, (base + i * inc) & 'hFF);
      cs = cs ^ ((base + i * inc) & 'hFF);
    end
    if (chk_en()) send(ph, cs);
  endtask

  initial begin
    int r, d;
    bit v, dn;
    model_reset();
    #12;
    apply_reset("reset");

    // Reset in the middle of a payload.
    send("midrst", 'hA1);
    for (int i = 0; i < 5; i++) send("midrst", i);
    apply_reset("midrst");
    send("midrst_go", 'h5A);
    check_eq("midrst_go.err", err, 1);

    // Load A with an address pattern.
    load_matrix("loadA", 'hA1, 0, 1);
    check_eq("loadA.a_loaded", a_loaded, 1);
    check_eq("loadA.err_cleared", err, 0);

    // Go with only A loaded.
    send("go_noB", 'h5A);
    check_eq("go_noB.err", err, 1);
    check_eq("go_noB.start", mm_start, 0);

    // Load B, run the multiply twice.
    load_matrix("loadB", 'hB2, 'h40, 3);
    check_eq("loadB.b_loaded", b_loaded, 1);
    send("go1", 'h5A);
    check_eq("go1.mm_start", mm_start, 1);
    check_eq("go1.busy", busy, 1);
    step("go1_donecoinc", 1'b1, 'hA1, 1'b1);
    check_eq("go1.start_one_cycle", mm_start, 0);
    check_eq("go1.ignore_early_done", busy, 1);
    quiet("go1_wait", 18);
    step("go1_done", 1'b0, 0, 1'b1);
    check_eq("go1.done_busy", busy, 0);
    send("go2", 'h5A);
    check_eq("go2.mm_start", mm_start, 1);
    quiet("go2_wait", 4);
    step("go2_done", 1'b0, 0, 1'b1);

    // Go with only B loaded, then a header clears err.
    apply_reset("rst2");
    load_matrix("onlyB", 'hB2, 7, 5);
    send("onlyB_go", 'h5A);
    check_eq("onlyB.err", err, 1);
    check_eq("onlyB.nostart", mm_start, 0);
    send("onlyB_hdrA", 'hA1);
    check_eq("onlyB.err_clear", err, 0);
    for (int i = 0; i < NN; i++) send("onlyB_fill", i);
    if (chk_en()) send("onlyB_fill", 0);

    // Timeout after 3 payload bytes.
    send("tmo", 'hB2);
    for (int i = 0; i < 3; i++) send("tmo", 'h10 + i);
    quiet("tmo_gap", TIMEOUT - 1);
    check_eq("tmo.not_yet", err, 0);
    quiet("tmo_fire", 1);
    check_eq("tmo.err", err, 1);
    check_eq("tmo.idle", busy, 0);
    check_eq("tmo.b_loaded", b_loaded, 0);

    // Byte arriving on the last possible cycle beats the timeout.
    send("tmo_edge", 'hA1);
    quiet("tmo_edge_gap", TIMEOUT - 1);
    send("tmo_edge_byte", 'h33);
    check_eq("tmo_edge.no_err", err, 0);
    check_eq("tmo_edge.busy", busy, 1);
    for (int i = 1; i < NN; i++) send("tmo_edge_fill", i);
    if (chk_en()) send("tmo_edge_fill", 0);

`ifdef LOADER_CHECKSUM_EN
    apply_reset("cs");
    send("cs_ok", 'hA1);
    for (int i = 0; i < NN; i++) send("cs_ok", 1);
    send("cs_ok", 'hA1);
    check_eq("cs_ok.a_loaded", a_loaded, 1);
    send("cs_bad", 'hA1);
    for (int i = 0; i < NN; i++) send("cs_bad", 1);
    send("cs_bad", 'h00);
    check_eq("cs_bad.err", err, 1);
    check_eq("cs_bad.a_loaded", a_loaded, 0);
`endif

    // Random byte traffic with sporadic done strobes.
    for (int i = 0; i < 4000; i++) begin
      r  = $urandom_range(0, 9);
      v  = ($urandom_range(0, 2) == 0);
      dn = ($urandom_range(0, 11) == 0);
      case (r)
        0: d = 'hA1;
        1: d = 'hB2;
        2, 3: d = 'h5A;
        default: d = $urandom_range(0, 255);
      endcase
      step("rand", v, d, dn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
